lbm_step_scheduler: RTL and testbench
=====================================

// Module: lbm_step_scheduler
// PURPOSE
//  Top-level sequencer for one LBM run. It loads the initial 9-direction pixel frame over the AXIS
//  stream into BRAM by metering the pixel-out writer's read_addr credit limit.
//  It then loops N timesteps: pulse the collide/stream core, wait; pulse the output drain, wait.
//  Sits beside the DDR pixel-out writer and owns its read_addr input; passively monitors the AXIS handshake.
// PARAMETERS
//  ADDRESS_WIDTH   12     BRAM address / pixel-count width
//  DEPTH           2500   max pixels per frame (BRAM depth)
//  WINDOW          64     credit window: max pixels load_limit may run ahead of beat count
//  STEP_WIDTH      16     width of step counter / cfg_num_steps
//  TIMEOUT_WIDTH   20     watchdog counter width; timeout at all-ones
// PORTS
//  m00_axis_aclk      in   1               clock
//  m00_axis_aresetn   in   1               reset, asynchronous, active-low
//  cfg_start          in   1               1-cycle start pulse, honoured only in IDLE
//  cfg_abort          in   1               synchronous abort, any state
//  cfg_num_pixels     in   ADDRESS_WIDTH   pixels per frame, valid range 1..DEPTH
//  cfg_num_steps      in   STEP_WIDTH      timesteps to run, valid range >=1
//  mon_tvalid         in   1               AXIS tvalid (monitor only)
//  mon_tready         in   1               AXIS tready (monitor only)
//  mon_tlast          in   1               AXIS tlast (monitor only)
//  load_limit         out  ADDRESS_WIDTH   drives writer read_addr; writer accepts while write_addr<load_limit
//  core_start         out  1               1-cycle pulse: begin one collide/stream step
//  core_done          in   1               1-cycle pulse from core
//  drain_start        out  1               1-cycle pulse: begin frame output
//  drain_done         in   1               1-cycle pulse from drain
//  busy               out  1               high in every state except IDLE
//  done               out  1               1-cycle pulse on successful completion
//  step_count         out  STEP_WIDTH      completed timesteps
//  err                out  2               0 none, 1 bad cfg, 2 early tlast, 3 timeout; sticky until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; load_limit=0, core_start=0, drain_start=0, busy=0, done=0, step_count=0, err=0.
//  All outputs are registered. Start pulses assert in the first cycle of the target state.
//  States: IDLE, LOAD, COMPUTE, DRAIN, FINISH.
//  IDLE: on cfg_start:
//   - cfg valid -> latch cfg, beat_cnt=0, step_count=0, err=0, go LOAD.
//   - cfg_num_pixels==0, >DEPTH, or cfg_num_steps==0 -> err=1, stay IDLE.
//  LOAD:
//   - beat = mon_tvalid&mon_tready; beat_cnt increments on each beat.
//   - load_limit <= min(beat_cnt+WINDOW, num_pixels), recomputed every cycle (next-cycle visible).
//   - Beat with tlast and beat_cnt+1 <  num_pixels -> err=2, go IDLE.
//   - Beat with beat_cnt+1 == num_pixels -> go COMPUTE, load_limit<=0; a missing tlast is tolerated.
//  COMPUTE: core_start pulse on entry; wait core_done -> DRAIN.
//  DRAIN: drain_start pulse on entry; wait drain_done -> step_count+1.
//   - Then if step_count+1==num_steps -> FINISH, else -> COMPUTE.
//  FINISH: done=1 for one cycle -> IDLE.
//  Watchdog: cleared on every state change and on each LOAD beat; increments otherwise in LOAD/COMPUTE/DRAIN.
//   - Reaching all-ones -> err=3, go IDLE.
//  Priority, highest first: abort > timeout > err=2 > normal transition.
//   - abort -> IDLE, load_limit=0, no done, err unchanged.
//  cfg_start outside IDLE is ignored. Done pulses arriving outside their wait state are ignored.
//   - Example: core_done seen in DRAIN does not advance.
//  Asynchronous reset mid-run: immediate return to reset values; no pulse outputs glitch.
//  Widths: beat_cnt is ADDRESS_WIDTH+1 bits so beat_cnt+WINDOW never wraps; min() is then truncated.
// TESTING
//  T1 num_pixels=10, steps=3, always-valid/ready source, tlast on beat 10 -> 3 core_start, 3 drain_start, done, step_count=3, err=0.
//  T2 num_pixels=200, WINDOW=64, source stalls -> load_limit never exceeds beat_cnt+64, reaches 200, then 0 in COMPUTE.
//  T3 tlast on beat 5 of 10 -> err=2, IDLE next cycle, busy=0, no core_start.
//  T4 cfg_num_pixels=0, then cfg_num_pixels=2501, then steps=0 -> err=1 each time, busy stays 0.
//  T5 core_done withheld -> err=3 after 2^TIMEOUT_WIDTH-1 cycles, IDLE; cfg_abort during DRAIN -> IDLE, no done.
//  T6 reset asserted mid-LOAD, then restart with a fresh frame -> beat_cnt=0, load_limit ramps from WINDOW, run completes.

Source files
------------

// File: rtl/lbm_step_scheduler.sv
// Run sequencer for one LBM simulation: meters the initial frame load into BRAM through the
// pixel-out writer's read_addr limit, then alternates collide/stream and drain for N timesteps.
module lbm_step_scheduler #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 2500,
  parameter int WINDOW        = 64,
  parameter int STEP_WIDTH    = 16,
  parameter int TIMEOUT_WIDTH = 20
) (
  input  logic                     m00_axis_aclk,
  input  logic                     m00_axis_aresetn,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic [ADDRESS_WIDTH-1:0] cfg_num_pixels,
  input  logic [STEP_WIDTH-1:0]    cfg_num_steps,
  input  logic                     mon_tvalid,
  input  logic                     mon_tready,
  input  logic                     mon_tlast,
  output logic [ADDRESS_WIDTH-1:0] load_limit,
  output logic                     core_start,
  input  logic                     core_done,
  output logic                     drain_start,
  input  logic                     drain_done,
  output logic                     busy,
  output logic                     done,
  output logic [STEP_WIDTH-1:0]    step_count,
  output logic [1:0]               err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [ADDRESS_WIDTH:0]   LP_WINDOW   = (ADDRESS_WIDTH+1)'(WINDOW);
  localparam logic [ADDRESS_WIDTH:0]   LP_CNT_ONE  = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] LP_DEPTH    = ADDRESS_WIDTH'(DEPTH);
  localparam logic [1:0]               ERR_NONE    = 2'd0;
  localparam logic [1:0]               ERR_CFG     = 2'd1;
  localparam logic [1:0]               ERR_TLAST   = 2'd2;
  localparam logic [1:0]               ERR_TIMEOUT = 2'd3;

  state_t                     r_state;
  logic [ADDRESS_WIDTH-1:0]   r_num_pixels;
  logic [STEP_WIDTH-1:0]      r_num_steps;
  logic [ADDRESS_WIDTH:0]     r_beat_cnt;
  logic [TIMEOUT_WIDTH-1:0]   r_wdog;
  logic [ADDRESS_WIDTH-1:0]   r_load_limit;
  logic                       r_core_start;
  logic                       r_drain_start;
  logic                       r_busy;
  logic                       r_done;
  logic [STEP_WIDTH-1:0]      r_step_count;
  logic [1:0]                 r_err;

  logic                       w_beat;
  logic [ADDRESS_WIDTH:0]     w_beat_next;
  logic [ADDRESS_WIDTH:0]     w_num_ext;
  logic                       w_last_beat;
  logic                       w_early_tlast;
  logic [ADDRESS_WIDTH:0]     w_limit_sum;
  logic [ADDRESS_WIDTH-1:0]   w_limit;
  logic [ADDRESS_WIDTH:0]     w_cfg_ext;
  logic [ADDRESS_WIDTH:0]     w_first_limit;
  logic [TIMEOUT_WIDTH-1:0]   w_wdog_next;
  logic                       w_timeout;
  logic                       w_active;
  logic                       w_cfg_bad;
  logic [STEP_WIDTH-1:0]      w_step_next;

  // beat_cnt carries one extra bit so beat_cnt+WINDOW cannot wrap before the min()
  assign w_beat        = mon_tvalid & mon_tready;
  assign w_beat_next   = r_beat_cnt + LP_CNT_ONE;
  assign w_num_ext     = {1'b0, r_num_pixels};
  assign w_last_beat   = w_beat & (w_beat_next == w_num_ext);
  assign w_early_tlast = w_beat & mon_tlast & (w_beat_next < w_num_ext);
  assign w_limit_sum   = r_beat_cnt + LP_WINDOW;
  assign w_limit       = (w_limit_sum < w_num_ext) ? w_limit_sum[ADDRESS_WIDTH-1:0] : r_num_pixels;
  assign w_cfg_ext     = {1'b0, cfg_num_pixels};
  assign w_first_limit = (LP_WINDOW < w_cfg_ext) ? LP_WINDOW : w_cfg_ext;
  assign w_wdog_next   = r_wdog + TIMEOUT_WIDTH'(1);
  assign w_timeout     = &w_wdog_next;
  assign w_active      = (r_state == S_LOAD) | (r_state == S_COMPUTE) | (r_state == S_DRAIN);
  assign w_cfg_bad     = (cfg_num_pixels == '0) | (cfg_num_pixels > LP_DEPTH) | (cfg_num_steps == '0);
  assign w_step_next   = r_step_count + STEP_WIDTH'(1);

  // Sequencer state, watchdog and all registered outputs
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_state       <= S_IDLE;
      r_num_pixels  <= '0;
      r_num_steps   <= '0;
      r_beat_cnt    <= '0;
      r_wdog        <= '0;
      r_load_limit  <= '0;
      r_core_start  <= 1'b0;
      r_drain_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_step_count  <= '0;
      r_err         <= ERR_NONE;
    end else begin
      r_core_start  <= 1'b0;
      r_drain_start <= 1'b0;
      r_done        <= 1'b0;
      if (cfg_abort) begin
        r_state      <= S_IDLE;
        r_busy       <= 1'b0;
        r_load_limit <= '0;
        r_wdog       <= '0;
      end else if (w_active && w_timeout) begin
        r_state      <= S_IDLE;
        r_busy       <= 1'b0;
        r_load_limit <= '0;
        r_wdog       <= '0;
        r_err        <= ERR_TIMEOUT;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_wdog <= '0;
            if (cfg_start) begin
              if (w_cfg_bad) begin
                r_err <= ERR_CFG;
              end else begin
                r_num_pixels <= cfg_num_pixels;
                r_num_steps  <= cfg_num_steps;
                r_beat_cnt   <= '0;
                r_step_count <= '0;
                r_err        <= ERR_NONE;
                r_load_limit <= w_first_limit[ADDRESS_WIDTH-1:0];
                r_busy       <= 1'b1;
                r_state      <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (w_early_tlast) begin
              r_err        <= ERR_TLAST;
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_load_limit <= '0;
              r_wdog       <= '0;
            end else if (w_last_beat) begin
              r_beat_cnt   <= w_beat_next;
              r_load_limit <= '0;
              r_core_start <= 1'b1;
              r_state      <= S_COMPUTE;
              r_wdog       <= '0;
            end else begin
              r_load_limit <= w_limit;
              if (w_beat) begin
                r_beat_cnt <= w_beat_next;
                r_wdog     <= '0;
              end else begin
                r_wdog <= w_wdog_next;
              end
            end
          end
          S_COMPUTE: begin
            if (core_done) begin
              r_drain_start <= 1'b1;
              r_state       <= S_DRAIN;
              r_wdog        <= '0;
            end else begin
              r_wdog <= w_wdog_next;
            end
          end
          S_DRAIN: begin
            if (drain_done) begin
              r_step_count <= w_step_next;
              r_wdog       <= '0;
              if (w_step_next == r_num_steps) begin
                r_done  <= 1'b1;
                r_state <= S_FINISH;
              end else begin
                r_core_start <= 1'b1;
                r_state      <= S_COMPUTE;
              end
            end else begin
              r_wdog <= w_wdog_next;
            end
          end
          S_FINISH: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_wdog  <= '0;
          end
          default: begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_load_limit <= '0;
            r_wdog       <= '0;
          end
        endcase
      end
    end
  end

  assign load_limit  = r_load_limit;
  assign core_start  = r_core_start;
  assign drain_start = r_drain_start;
  assign busy        = r_busy;
  assign done        = r_done;
  assign step_count  = r_step_count;
  assign err         = r_err;

endmodule

// File: tb/tb_lbm_step_scheduler.sv
// Randomized bench for lbm_step_scheduler: a frame-level reference (beat counts, credit window
// arithmetic, expected pulse totals) plus core/drain responders with random latency.
module tb_lbm_step_scheduler;

  localparam int AW    = 12;
  localparam int DEPTH = 2500;
  localparam int W     = 64;
  localparam int SW    = 16;
  localparam int TW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [AW-1:0] cfg_num_pixels = '0;
  logic [SW-1:0] cfg_num_steps = '0;
  logic          mon_tvalid = 1'b0;
  logic          mon_tready = 1'b0;
  logic          mon_tlast = 1'b0;
  logic [AW-1:0] load_limit;
  logic          core_start;
  logic          core_done = 1'b0;
  logic          drain_start;
  logic          drain_done = 1'b0;
  logic          busy;
  logic          done;
  logic [SW-1:0] step_count;
  logic [1:0]    err;

  lbm_step_scheduler #(
    .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .WINDOW(W), .STEP_WIDTH(SW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_pixels(cfg_num_pixels), .cfg_num_steps(cfg_num_steps),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .load_limit(load_limit),
    .core_start(core_start), .core_done(core_done),
    .drain_start(drain_start), .drain_done(drain_done),
    .busy(busy), .done(done), .step_count(step_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // pulse counters, sampled mid-cycle
  int n_core = 0;
  int n_drain = 0;
  int n_done = 0;
  always @(negedge clk) begin
    if (core_start === 1'b1) n_core++;
    if (drain_start === 1'b1) n_drain++;
    if (done === 1'b1) n_done++;
  end

  // core/drain responders; "spurious" fires the other unit's done while waiting
  bit withhold_core = 1'b0;
  bit withhold_drain = 1'b0;
  bit spurious = 1'b0;
  int core_wait = -1;
  int drain_wait = -1;
  always @(negedge clk) begin
    core_done = 1'b0;
    drain_done = 1'b0;
    if (!rst_n) begin
      core_wait = -1;
      drain_wait = -1;
    end else begin
      if (core_start === 1'b1 && !withhold_core) begin
        core_wait = $urandom_range(1, 4);
        if (spurious) drain_done = 1'b1;
      end
      if (drain_start === 1'b1 && !withhold_drain) begin
        drain_wait = $urandom_range(1, 4);
        if (spurious) core_done = 1'b1;
      end
      if (core_wait == 0) core_done = 1'b1;
      if (core_wait >= 0) core_wait--;
      if (drain_wait == 0) drain_done = 1'b1;
      if (drain_wait >= 0) drain_wait--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_limit"}, load_limit, 0);
    check_val({tag, "_core_start"}, core_start, 0);
    check_val({tag, "_drain_start"}, drain_start, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_step_count"}, step_count, 0);
    check_val({tag, "_err"}, err, 0);
  endtask

  task automatic start_cfg(input int n, input int s, input bit ok);
    cfg_num_pixels = AW'(n);
    cfg_num_steps  = SW'(s);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    if (ok) begin
      check_val("start_busy", busy, 1);
      check_val("start_err", err, 0);
      check_val("start_steps", step_count, 0);
      check_val("start_limit", load_limit, imin(W, n));
    end else begin
      check_val("badcfg_busy", busy, 0);
      check_val("badcfg_err", err, 1);
    end
  endtask

  // tl: beat number carrying tlast (0 = never)
  task automatic load_frame(input int n, input int pv, input int pr, input int tl, output bit early);
    int prev = 0;
    bit loading = 1'b1;
    early = 1'b0;
    for (int cyc = 0; loading && cyc < 20000; cyc++) begin
      bit v, r, beat;
      v = ($urandom_range(0, 99) < pv);
      r = ($urandom_range(0, 99) < pr);
      beat = v && r;
      mon_tvalid = v;
      mon_tready = r;
      mon_tlast  = (prev + 1 == tl);
      tick();
      if (beat && prev + 1 == n) begin
        check_val("load_end_limit", load_limit, 0);
        check_val("load_end_core_start", core_start, 1);
        check_val("load_end_busy", busy, 1);
        loading = 1'b0;
      end else if (beat && prev + 1 == tl) begin
        check_val("early_err", err, 2);
        check_val("early_busy", busy, 0);
        loading = 1'b0;
        early = 1'b1;
      end else begin
        check_val("load_limit", load_limit, imin(prev + W, n));
        if (beat) prev++;
      end
    end
    check_val("load_finished", loading, 0);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic run_steps(input int s, input int c0, input int d0, input int e0);
    bit seen = 1'b0;
    for (int cyc = 0; !seen && cyc < s * 20 + 40; cyc++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        check_val("done_step_count", step_count, s);
      end
    end
    check_val("done_seen", seen, 1);
    tick();
    check_val("after_done_busy", busy, 0);
    check_val("after_done_done", done, 0);
    check_val("after_done_err", err, 0);
    check_val("core_start_total", n_core - c0, s);
    check_val("drain_start_total", n_drain - d0, s);
    check_val("done_total", n_done - e0, 1);
  endtask

  task automatic run_frame(input int n, input int s, input int pv, input int pr, input int tl,
                           input bit spur);
    int c0 = n_core;
    int d0 = n_drain;
    int e0 = n_done;
    bit early;
    spurious = spur;
    start_cfg(n, s, 1'b1);
    load_frame(n, pv, pr, tl, early);
    if (!early) begin
      run_steps(s, c0, d0, e0);
    end else begin
      repeat (4) tick();
      check_val("early_still_idle", busy, 0);
      check_val("early_err_sticky", err, 2);
      check_val("early_no_core_start", n_core - c0, 0);
    end
    spurious = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit early;
    int c0, e0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
    check_reset_values("post_reset");

    run_frame(10, 3, 100, 100, 10, 1'b0);
    run_frame(200, 2, 40, 60, 200, 1'b0);
    run_frame(20, 3, 100, 100, 20, 1'b1);
    run_frame(1, 1, 100, 100, 1, 1'b0);
    run_frame(DEPTH, 1, 100, 100, DEPTH, 1'b0);
    run_frame(30, 2, 100, 100, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      int n, s, tl;
      n = $urandom_range(1, 150);
      s = $urandom_range(1, 4);
      case ($urandom_range(0, 3))
        0:       tl = 0;
        1:       tl = (n > 1) ? int'($urandom_range(1, n - 1)) : n;
        default: tl = n;
      endcase
      run_frame(n, s, $urandom_range(30, 100), $urandom_range(30, 100), tl, 1'($urandom_range(0, 1)));
    end

    run_frame(10, 2, 100, 100, 5, 1'b0);

    // each bad config is preceded by an accepted start + abort so err starts from 0
    for (int k = 0; k < 3; k++) begin
      start_cfg(5, 1, 1'b1);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      check_val("abort_load_busy", busy, 0);
      check_val("abort_load_err", err, 0);
      case (k)
        0:       start_cfg(0, 1, 1'b0);
        1:       start_cfg(DEPTH + 1, 1, 1'b0);
        default: start_cfg(5, 0, 1'b0);
      endcase
    end

    withhold_core = 1'b1;
    start_cfg(4, 2, 1'b1);
    load_frame(4, 100, 100, 4, early);
    repeat ((1 << TW) - 2) tick();
    check_val("wdog_not_yet", busy, 1);
    tick();
    check_val("wdog_busy", busy, 0);
    check_val("wdog_err", err, 3);
    check_val("wdog_limit", load_limit, 0);
    withhold_core = 1'b0;

    withhold_drain = 1'b1;
    start_cfg(3, 2, 1'b1);
    load_frame(3, 100, 100, 3, early);
    begin
      bit got = 1'b0;
      for (int cyc = 0; !got && cyc < 20; cyc++) begin
        tick();
        if (drain_start === 1'b1) got = 1'b1;
      end
      check_val("drain_reached", got, 1);
    end
    cfg_num_pixels = '0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check_val("start_ignored_err", err, 0);
    check_val("start_ignored_busy", busy, 1);
    e0 = n_done;
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check_val("abort_drain_busy", busy, 0);
    check_val("abort_drain_err", err, 0);
    check_val("abort_drain_steps", step_count, 0);
    repeat (5) tick();
    check_val("abort_no_done", n_done - e0, 0);
    withhold_drain = 1'b0;

    start_cfg(100, 2, 1'b1);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midload_reset");
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    c0 = n_core;
    check_val("reset_no_core_start", n_core - c0, 0);
    run_frame(60, 2, 70, 80, 60, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
